// File: rtl/cpu16_pkg.sv
// ---------------------------------------------------------------------------
// cpu16_pkg
// Shared types and default widths for the cpu16 core and its program memory.
//   WORD_W           default instruction word width
//   ADDR_W           default word-address width
//   word_t / addr_t  convenience types at the default widths
//   prog_mem_state_e loader/fetch arbitration states of prog_mem
// ---------------------------------------------------------------------------
package cpu16_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // RUN   : fetch port live, loader idle
  // LOAD  : collecting bytes into the packer
  // WRITE : one cycle, the packed word goes into the RAM
  // DONE  : one cycle, ld_done pulse before handing the RAM back to fetch
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } prog_mem_state_e;

endpackage

// File: rtl/prog_mem_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs a stream of bytes into one word, first byte in the most significant
// position. A word is declared full either when its last byte slot is filled
// or when the byte carries the end-of-image flag; in the latter case the
// unfilled low bytes stay zero.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_clear      drop the current word and restart at the top byte
//   i_byte_en    a byte is being consumed this cycle
//   i_byte       byte value
//   i_last       consumed byte is the final one of the image
//   o_word       packed word (valid once o_word_full has been seen)
//   o_word_full  combinational: this cycle's byte completes the word
// ---------------------------------------------------------------------------
module byte_packer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_byte_en,
  input  logic [7:0]        i_byte,
  input  logic              i_last,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_full
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_placed;

  // Each byte is dropped straight into its slot rather than shifted along,
  // so a word cut short by i_last is already zero-padded at the bottom.
  assign w_placed    = DATA_W'(i_byte) << (8 * (BYTES - 1 - int'(r_count)));
  assign o_word_full = i_byte_en && ((r_count == CNT_W'(BYTES - 1)) || i_last);
  assign o_word      = r_word;

  // Accumulate bytes; the owner clears the packer once the word is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (i_byte_en) begin
      r_word  <= r_word | w_placed;
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem
// Program memory for the cpu16 core: a single-port RAM with a registered
// read serving instruction fetch, plus a byte-stream loader that rewrites
// the image at run time. While a load is in progress fetch is refused and
// cpu_hold asks the core to wait.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_req/fetch_addr       read request, taken when fetch_ready=1
//   fetch_ready                high only while idle (RUN)
//   fetch_valid/fetch_data     read result, one cycle after the request
//   cpu_hold                   high while the loader owns the RAM
//   ld_start/ld_base           begin a load at word address ld_base
//   ld_byte_valid/ld_byte      byte stream, MSB-first within each word
//   ld_last                    marks the final byte of the image
//   ld_byte_ready              high while a byte can be consumed
//   ld_done                    single-cycle end-of-load pulse
//   ld_error                   sticky: a word fell outside the RAM
// ---------------------------------------------------------------------------
module prog_mem
  import cpu16_pkg::*;
#(
  parameter int DATA_W    = cpu16_pkg::WORD_W,
  parameter int ADDR_W    = cpu16_pkg::ADDR_W,
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_byte_ready,
  output logic              ld_done,
  output logic              ld_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  prog_mem_state_e   r_state;
  prog_mem_state_e   w_nextState;
  logic [ADDR_W-1:0] r_wrAddr;
  logic              r_lastSeen;
  logic              r_error;
  logic              r_fetchValid;
  logic              r_fetchOob;
  logic [DATA_W-1:0] r_rdData;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_packWord;
  logic              w_packFull;
  logic              w_byteEn;
  logic              w_rdEn;
  logic              w_wrEn;
  logic              w_wrInRange;
  logic [IDX_W-1:0]  w_ramIdx;

  // The comparison is done one bit wider so DEPTH == 2**ADDR_W still works.
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  assign w_byteEn    = (r_state == LOAD) && ld_byte_valid;
  assign w_rdEn      = (r_state == RUN) && fetch_req;
  assign w_wrInRange = inRange(r_wrAddr);
  assign w_wrEn      = (r_state == WRITE) && w_wrInRange;

  // The RAM has a single port: the loader owns it only in WRITE, and fetch
  // cannot be accepted then, so the two never collide.
  assign w_ramIdx = (r_state == WRITE) ? r_wrAddr[IDX_W-1:0]
                                       : fetch_addr[IDX_W-1:0];

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (r_state == WRITE),
    .i_byte_en   (w_byteEn),
    .i_byte      (ld_byte),
    .i_last      (ld_last),
    .o_word      (w_packWord),
    .o_word_full (w_packFull)
  );

  // Next state and the handshake outputs, all decoded from the state.
  always_comb begin
    w_nextState   = r_state;
    fetch_ready   = 1'b0;
    cpu_hold      = 1'b1;
    ld_byte_ready = 1'b0;
    ld_done       = 1'b0;
    case (r_state)
      RUN: begin
        fetch_ready = 1'b1;
        cpu_hold    = 1'b0;
        if (ld_start) w_nextState = LOAD;
      end
      LOAD: begin
        ld_byte_ready = 1'b1;
        if (w_packFull) w_nextState = WRITE;
      end
      WRITE: begin
        w_nextState = r_lastSeen ? DONE : LOAD;
      end
      DONE: begin
        ld_done     = 1'b1;
        w_nextState = RUN;
      end
      default: w_nextState = RUN;
    endcase
  end

  // State register and loader bookkeeping. The write address wraps freely;
  // a wrapped address that is still out of range simply keeps flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wrAddr   <= '0;
      r_lastSeen <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        RUN: begin
          if (ld_start) begin
            r_wrAddr   <= ld_base;
            r_lastSeen <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        LOAD: begin
          if (w_packFull) r_lastSeen <= ld_last;
        end
        WRITE: begin
          r_wrAddr <= r_wrAddr + ADDR_W'(1);
          if (!w_wrInRange) r_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fetch result qualifiers. Out-of-range reads still answer, but with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchValid <= 1'b0;
      r_fetchOob   <= 1'b0;
    end else begin
      r_fetchValid <= w_rdEn;
      r_fetchOob   <= !inRange(fetch_addr);
    end
  end

  // RAM array: no reset so it maps onto block RAM and keeps its image.
  always @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[w_ramIdx] <= w_packWord;
    end else if (w_rdEn) begin
      r_rdData <= r_mem[w_ramIdx];
    end
  end

  // Power-up image: all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // Gating the data with valid keeps the output at zero after reset even
  // though the read register itself is never reset.
  assign fetch_valid = r_fetchValid;
  assign fetch_data  = (r_fetchValid && !r_fetchOob) ? r_rdData : '0;
  assign ld_error    = r_error;

endmodule

// File: tb/tb_prog_mem.sv
// ---------------------------------------------------------------------------
// tb_prog_mem
// Self-checking bench for prog_mem (DATA_W=16, ADDR_W=16, DEPTH=1024).
// A transaction-level model tracks the memory image and which phase of a
// load the block should be in; a compare process checks every DUT output
// against it each cycle. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_prog_mem;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        cpu_hold;
  logic        ld_start;
  logic [15:0] ld_base;
  logic        ld_byte_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_byte_ready;
  logic        ld_done;
  logic        ld_error;

  int errCount   = 0;
  int checkCount = 0;
  bit cmpEnable  = 0;

  // model state
  logic [15:0] mdl [DEPTH];
  logic [7:0]  mBytes [$];
  logic [15:0] mWrAddr;
  bit          mWritePending;
  bit          mLast;
  bit          expReady, expHold, expByteReady, expDone, expError, expValid;
  logic [15:0] expData;

  // co-fetch request issued together with ld_start
  bit          coFetch  = 0;
  logic [15:0] coAddr   = 0;
  logic [15:0] coExpect = 0;
  logic [7:0]  loadBytes [16];

  prog_mem #(
    .DATA_W    (16),
    .ADDR_W    (16),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
    .cpu_hold      (cpu_hold),
    .ld_start      (ld_start),
    .ld_base       (ld_base),
    .ld_byte_valid (ld_byte_valid),
    .ld_byte       (ld_byte),
    .ld_last       (ld_last),
    .ld_byte_ready (ld_byte_ready),
    .ld_done       (ld_done),
    .ld_error      (ld_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
  end

  // Reference model: what the block must show after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expReady = 1; expHold = 0; expByteReady = 0; expDone = 0;
      expError = 0; expValid = 0; expData = 16'h0000;
      mWritePending = 0; mLast = 0; mBytes.delete();
    end else begin
      if (fetch_req && expReady) begin
        expValid = 1;
        expData  = (fetch_addr < DEPTH) ? mdl[fetch_addr[9:0]] : 16'h0000;
      end else begin
        expValid = 0;
        expData  = 16'h0000;
      end
      if (expDone) begin
        expDone = 0; expHold = 0; expReady = 1;
      end else if (mWritePending) begin
        if (mWrAddr < DEPTH)
          mdl[mWrAddr[9:0]] = {mBytes[0], (mBytes.size() > 1) ? mBytes[1] : 8'h00};
        else
          expError = 1;
        mWrAddr = mWrAddr + 16'd1;
        mBytes.delete();
        mWritePending = 0;
        if (mLast) expDone = 1;
        else       expByteReady = 1;
      end else if (expByteReady) begin
        if (ld_byte_valid) begin
          mBytes.push_back(ld_byte);
          if (ld_last || mBytes.size() == 2) begin
            mWritePending = 1;
            mLast = ld_last;
            expByteReady = 0;
          end
        end
      end else if (expReady && ld_start) begin
        expReady = 0; expHold = 1; expByteReady = 1; expError = 0;
        mWrAddr = ld_base;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  initial begin
    wait (cmpEnable);
    forever begin
      @(posedge clk);
      #1;
      checkOutput("fetch_ready",   32'(fetch_ready),   32'(expReady));
      checkOutput("cpu_hold",      32'(cpu_hold),      32'(expHold));
      checkOutput("ld_byte_ready", 32'(ld_byte_ready), 32'(expByteReady));
      checkOutput("ld_done",       32'(ld_done),       32'(expDone));
      checkOutput("ld_error",      32'(ld_error),      32'(expError));
      checkOutput("fetch_valid",   32'(fetch_valid),   32'(expValid));
      checkOutput("fetch_data",    32'(fetch_data),    32'(expData));
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit last);
    int budget = 0;
    ld_byte_valid = 1; ld_byte = b; ld_last = last;
    while (ld_byte_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) checkOutput("byte_ready_timeout", 32'd0, 32'd1);
    else              checkOutput("cpu_hold_in_load", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    ld_byte_valid = 0; ld_last = 0;
  endtask

  // One complete load of loadBytes[0..len-1] at base, optional idle gaps.
  task automatic applyStimulus(input logic [15:0] base, input int len, input bit gaps);
    int budget = 0;
    ld_start = 1; ld_base = base;
    fetch_req = coFetch; fetch_addr = coAddr;
    @(negedge clk);
    if (coFetch) begin
      checkOutput("cofetch_valid", 32'(fetch_valid), 32'd1);
      checkOutput("cofetch_data",  32'(fetch_data),  32'(coExpect));
      checkOutput("cofetch_ready_low", 32'(fetch_ready), 32'd0);
    end
    ld_start = 0; fetch_req = 0;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          fetch_req = 1'($urandom); fetch_addr = 16'($urandom_range(0, 15));
          ld_start = 1'($urandom); ld_base = 16'($urandom);
          @(negedge clk);
        end
        fetch_req = 0; ld_start = 0;
      end
      sendByte(loadBytes[i], i == len - 1);
    end
    while (ld_done !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("ld_done_pulse", 32'(ld_done), 32'd1);
    @(negedge clk);
    checkOutput("ready_after_done", 32'(fetch_ready), 32'd1);
  endtask

  task automatic fetchOne(input logic [15:0] addr, input logic [15:0] exp, input string name);
    fetch_req = 1; fetch_addr = addr;
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(fetch_valid), 32'd1);
    checkOutput({name, "_data"},  32'(fetch_data),  32'(exp));
    fetch_req = 0;
  endtask

  initial begin
    rst_n = 0; fetch_req = 0; fetch_addr = 0; ld_start = 0; ld_base = 0;
    ld_byte_valid = 0; ld_byte = 0; ld_last = 0;
    repeat (3) @(negedge clk);
    cmpEnable = 1;
    checkOutput("reset_fetch_ready", 32'(fetch_ready), 32'd1);
    checkOutput("reset_cpu_hold",    32'(cpu_hold),    32'd0);
    checkOutput("reset_fetch_data",  32'(fetch_data),  32'd0);
    rst_n = 1;
    @(negedge clk);

    // image 700F/8002 at 0, then back-to-back fetch
    loadBytes[0] = 8'h70; loadBytes[1] = 8'h0F; loadBytes[2] = 8'h80; loadBytes[3] = 8'h02;
    applyStimulus(16'h0000, 4, 0);
    fetch_req = 1; fetch_addr = 16'h0000;
    @(negedge clk);
    checkOutput("b2b_first", 32'(fetch_data), 32'h700F);
    fetch_addr = 16'h0001;
    @(negedge clk);
    checkOutput("b2b_second", 32'(fetch_data), 32'h8002);
    fetch_req = 0;
    @(negedge clk);
    checkOutput("valid_drops", 32'(fetch_valid), 32'd0);

    fetchOne(16'hFFFF, 16'h0000, "oob_fetch");

    loadBytes[0] = 8'hAB; loadBytes[1] = 8'hCD; loadBytes[2] = 8'h12; loadBytes[3] = 8'h34;
    applyStimulus(16'h0010, 4, 0);
    checkOutput("model_10", 32'(mdl[10'h010]), 32'hABCD);
    fetchOne(16'h0010, 16'hABCD, "f10");
    fetchOne(16'h0011, 16'h1234, "f11");

    loadBytes[0] = 8'h55;
    applyStimulus(16'h0020, 1, 0);
    checkOutput("pad_error", 32'(ld_error), 32'd0);
    fetchOne(16'h0020, 16'h5500, "f20");

    loadBytes[0] = 8'h11; loadBytes[1] = 8'h22; loadBytes[2] = 8'h33; loadBytes[3] = 8'h44;
    applyStimulus(16'h03FF, 4, 0);
    checkOutput("model_3ff", 32'(mdl[10'h3FF]), 32'h1122);
    fetchOne(16'h03FF, 16'h1122, "f3ff");
    repeat (4) @(negedge clk);
    checkOutput("error_sticky", 32'(ld_error), 32'd1);

    // fetch and ld_start together: the fetch still returns old data
    coFetch = 1; coAddr = 16'h0010; coExpect = 16'hABCD;
    loadBytes[0] = 8'h66;
    applyStimulus(16'h0021, 1, 0);
    coFetch = 0;
    checkOutput("error_cleared", 32'(ld_error), 32'd0);

    // wrap from the top of the address space back into range
    loadBytes[0] = 8'hDE; loadBytes[1] = 8'hAD; loadBytes[2] = 8'hBE; loadBytes[3] = 8'hEF;
    applyStimulus(16'hFFFF, 4, 0);
    checkOutput("wrap_error", 32'(ld_error), 32'd1);
    fetchOne(16'h0000, 16'hBEEF, "wrap0");

    // reset after three bytes: first word kept, partial second word lost
    ld_start = 1; ld_base = 16'h0030;
    @(negedge clk);
    ld_start = 0;
    sendByte(8'hA1, 0); sendByte(8'hA2, 0); sendByte(8'hA3, 0);
    rst_n = 0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(fetch_ready), 32'd1);
    checkOutput("rst_hold",  32'(cpu_hold),    32'd0);
    rst_n = 1;
    @(negedge clk);
    fetchOne(16'h0030, 16'hA1A2, "f30");
    fetchOne(16'h0031, 16'h0000, "f31");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 8)) begin
          fetch_req = 1'($urandom_range(0, 3) != 0);
          fetch_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h40F));
          ld_byte_valid = 1'($urandom); ld_byte = 8'($urandom);
          @(negedge clk);
        end
        fetch_req = 0; ld_byte_valid = 0;
      end else begin
        int len;
        logic [15:0] base;
        len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) loadBytes[i] = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       base = 16'($urandom_range(16'h3F8, 16'h400));
          1:       base = 16'($urandom_range(16'hFFFC, 16'hFFFF));
          default: base = 16'($urandom_range(0, 16'h3F0));
        endcase
        applyStimulus(base, len, 1'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
